// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and writeback stage.
// Non-memory instructions write back combinationally in the cycle they arrive.
// Loads and stores issue a registered request, stall upstream while in REQ, and
// complete on memReady or abort after MEM_TIMEOUT REQ cycles (sticky memErr).
// Optional feature macro: MEM_WB_BYPASS_EN adds registered forwarding outputs
// fwdValid/fwdIndex/fwdData that mirror the previous cycle's register write.
//
// Handshake: a request is presented while memRdEn or memWrEn is high and is
// held stable until the cycle in which memReady is seen high (transfer
// completes in that cycle; load data is valid on memRdData in that same cycle)
// or the timeout abort fires. memReady is ignored while no request is active.
module mem_wb_stage #(
  parameter int DBITS       = 32,
  parameter int REGNO_BITS  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REGNO_BITS-1:0] inWrtIndex,
  input  logic                  inRegWrEn,
  input  logic [1:0]            inMulSel,
  input  logic [DBITS-1:0]      inAluOut,
  input  logic [DBITS-1:0]      inData2Out,
  input  logic [DBITS-1:0]      inPC,
  input  logic [DBITS-1:0]      inSysDataOut,
  input  logic                  inIsLoad,
  input  logic                  inIsStore,
  output logic [DBITS-1:0]      memAddr,
  output logic [DBITS-1:0]      memWrData,
  output logic                  memRdEn,
  output logic                  memWrEn,
  input  logic                  memReady,
  input  logic [DBITS-1:0]      memRdData,
  output logic                  regWrEn,
  output logic [REGNO_BITS-1:0] regWrIndex,
  output logic [DBITS-1:0]      regWrData,
  output logic                  memStall,
  output logic                  memErr
`ifdef MEM_WB_BYPASS_EN
  ,
  output logic                  fwdValid,
  output logic [REGNO_BITS-1:0] fwdIndex,
  output logic [DBITS-1:0]      fwdData
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [DBITS-1:0]        mem_addr_q, mem_addr_d;
  logic [DBITS-1:0]        mem_wr_data_q, mem_wr_data_d;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [REGNO_BITS-1:0]   wrt_index_q, wrt_index_d;
  logic                    reg_wr_en_q, reg_wr_en_d;
  logic [1:0]              mul_sel_q, mul_sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    mem_err_q, mem_err_d;
  logic                    mem_op;
  logic                    reg_wr_en;
  logic [REGNO_BITS-1:0]   reg_wr_index;
  logic [DBITS-1:0]        reg_wr_data;
  logic                    mem_stall;

  // Writeback source select shared by the direct path and load completion.
  function automatic logic [DBITS-1:0] wb_mux(
    input logic [1:0]       sel,
    input logic [DBITS-1:0] alu,
    input logic [DBITS-1:0] rd,
    input logic [DBITS-1:0] pc,
    input logic [DBITS-1:0] sys
  );
    logic [DBITS-1:0] r;
    case (sel)
      2'd0:    r = alu;
      2'd1:    r = rd;
      2'd2:    r = pc;
      default: r = sys;
    endcase
    return r;
  endfunction

  assign mem_op = inIsLoad | inIsStore;

  // Next-state, request registers and writeback outputs.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_wr_en_d   = mem_wr_en_q;
    wrt_index_d   = wrt_index_q;
    reg_wr_en_d   = reg_wr_en_q;
    mul_sel_d     = mul_sel_q;
    cnt_d         = cnt_q;
    mem_err_d     = mem_err_q;
    reg_wr_en     = 1'b0;
    reg_wr_index  = inWrtIndex;
    reg_wr_data   = wb_mux(inMulSel, inAluOut, memRdData, inPC, inSysDataOut);
    mem_stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          reg_wr_en = inRegWrEn;
        end else begin
          // Accept the access; a simultaneous load+store is issued as a store.
          mem_stall     = 1'b1;
          wrt_index_d   = inWrtIndex;
          reg_wr_en_d   = inRegWrEn;
          mul_sel_d     = inMulSel;
          mem_addr_d    = inAluOut;
          mem_wr_data_d = inData2Out;
          mem_wr_en_d   = inIsStore;
          mem_rd_en_d   = inIsLoad & ~inIsStore;
          cnt_d         = 8'd0;
          state_d       = REQ;
        end
      end
      REQ: begin
        reg_wr_index = wrt_index_q;
        reg_wr_data  = wb_mux(mul_sel_q, inAluOut, memRdData, inPC, inSysDataOut);
        if (memReady) begin
          reg_wr_en   = mem_rd_en_q & reg_wr_en_q;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Hung access: release the pipeline without writing back.
          mem_err_d   = 1'b1;
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      wrt_index_q   <= '0;
      reg_wr_en_q   <= 1'b0;
      mul_sel_q     <= 2'd0;
      cnt_q         <= 8'd0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      wrt_index_q   <= wrt_index_d;
      reg_wr_en_q   <= reg_wr_en_d;
      mul_sel_q     <= mul_sel_d;
      cnt_q         <= cnt_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign memAddr    = mem_addr_q;
  assign memWrData  = mem_wr_data_q;
  assign memRdEn    = mem_rd_en_q;
  assign memWrEn    = mem_wr_en_q;
  assign memErr     = mem_err_q;
  assign regWrEn    = reg_wr_en;
  assign regWrIndex = reg_wr_index;
  assign regWrData  = reg_wr_data;
  assign memStall   = mem_stall;

`ifdef MEM_WB_BYPASS_EN
  logic                  fwd_valid_q, fwd_valid_d;
  logic [REGNO_BITS-1:0] fwd_index_q, fwd_index_d;
  logic [DBITS-1:0]      fwd_data_q, fwd_data_d;

  // Capture this cycle's register write for a one-cycle-late bypass.
  always_comb begin
    fwd_valid_d = reg_wr_en;
    fwd_index_d = reg_wr_index;
    fwd_data_d  = reg_wr_data;
  end

  // Forwarding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_index_q <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_index_q <= fwd_index_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwdValid = fwd_valid_q;
  assign fwdIndex = fwd_index_q;
  assign fwdData  = fwd_data_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven and randomized checks of mem_wb_stage
// (built with MEM_TIMEOUT=4 so the abort path is reached quickly).
module tb_mem_wb_stage;

  localparam int DBITS   = 32;
  localparam int RB      = 4;
  localparam int TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [RB-1:0]   inWrtIndex;
  logic            inRegWrEn;
  logic [1:0]      inMulSel;
  logic [31:0]     inAluOut, inData2Out, inPC, inSysDataOut;
  logic            inIsLoad, inIsStore;
  logic [31:0]     memAddr, memWrData;
  logic            memRdEn, memWrEn;
  logic            memReady;
  logic [31:0]     memRdData;
  logic            regWrEn;
  logic [RB-1:0]   regWrIndex;
  logic [31:0]     regWrData;
  logic            memStall, memErr;
`ifdef MEM_WB_BYPASS_EN
  logic            fwdValid;
  logic [RB-1:0]   fwdIndex;
  logic [31:0]     fwdData;
`endif

  int vec_cnt  = 0;
  int mis_cnt  = 0;
  logic err_m  = 1'b0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu, pc, sys, rd;
    logic [3:0]  idx;
    logic        wen;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  mem_wb_stage #(.DBITS(DBITS), .REGNO_BITS(RB), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn), .inMulSel(inMulSel),
    .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
    .inSysDataOut(inSysDataOut), .inIsLoad(inIsLoad), .inIsStore(inIsStore),
    .memAddr(memAddr), .memWrData(memWrData), .memRdEn(memRdEn),
    .memWrEn(memWrEn), .memReady(memReady), .memRdData(memRdData),
    .regWrEn(regWrEn), .regWrIndex(regWrIndex), .regWrData(regWrData),
    .memStall(memStall), .memErr(memErr)
`ifdef MEM_WB_BYPASS_EN
    , .fwdValid(fwdValid), .fwdIndex(fwdIndex), .fwdData(fwdData)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    inWrtIndex = '0; inRegWrEn = 1'b0; inMulSel = 2'd0;
    inAluOut = '0; inData2Out = '0; inPC = '0; inSysDataOut = '0;
    inIsLoad = 1'b0; inIsStore = 1'b0; memReady = 1'b0; memRdData = '0;
  endtask

  function automatic logic [31:0] src_of(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] rd, input logic [31:0] pc,
                                         input logic [31:0] sys);
    return (sel == 2'd0) ? alu : (sel == 2'd1) ? rd : (sel == 2'd2) ? pc : sys;
  endfunction

  // One random instruction judged against the transaction-level model.
  task automatic run_random();
    int   op;
    int   w;
    logic is_ld, is_st, done;
    op = $urandom_range(0, 3);
    clear_inputs();
    inMulSel = 2'($urandom_range(0, 3));
    inWrtIndex = 4'($urandom_range(0, 15));
    inRegWrEn = 1'($urandom_range(0, 1));
    inAluOut = $urandom; inData2Out = $urandom; inPC = $urandom;
    inSysDataOut = $urandom; memRdData = $urandom;
    memReady = 1'($urandom_range(0, 1));
    is_st = (op == 3);
    is_ld = (op == 2);
    inIsStore = is_st;
    inIsLoad  = is_ld | (is_st & 1'($urandom_range(0, 1)));
    #1;
    chk("rnd_err", {31'd0, memErr}, {31'd0, err_m});
    if (op < 2) begin
      chk("rnd_alu_wen", {31'd0, regWrEn}, {31'd0, inRegWrEn});
      chk("rnd_alu_idx", {28'd0, regWrIndex}, {28'd0, inWrtIndex});
      chk("rnd_alu_data", regWrData, src_of(inMulSel, inAluOut, memRdData, inPC, inSysDataOut));
      chk("rnd_alu_stall", {31'd0, memStall}, 32'd0);
      next_cycle();
    end else begin
      chk("rnd_acc_stall", {31'd0, memStall}, 32'd1);
      chk("rnd_acc_wen", {31'd0, regWrEn}, 32'd0);
      next_cycle();
      w = $urandom_range(0, 5);
      done = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
        memReady  = (c == w);
        memRdData = $urandom;
        #1;
        chk("rnd_rden", {31'd0, memRdEn}, {31'd0, is_ld});
        chk("rnd_wren", {31'd0, memWrEn}, {31'd0, is_st});
        chk("rnd_addr", memAddr, inAluOut);
        if (is_st) chk("rnd_wdata", memWrData, inData2Out);
        if (c == w) begin
          done = 1'b1;
          chk("rnd_cmp_wen", {31'd0, regWrEn}, {31'd0, is_ld & inRegWrEn});
          if (is_ld && inRegWrEn) begin
            chk("rnd_cmp_idx", {28'd0, regWrIndex}, {28'd0, inWrtIndex});
            chk("rnd_cmp_data", regWrData, src_of(inMulSel, inAluOut, memRdData, inPC, inSysDataOut));
          end
          chk("rnd_cmp_stall", {31'd0, memStall}, 32'd0);
        end else if (c == TIMEOUT - 1) begin
          done = 1'b1;
          err_m = 1'b1;
          chk("rnd_abort_stall", {31'd0, memStall}, 32'd0);
          chk("rnd_abort_wen", {31'd0, regWrEn}, 32'd0);
        end else begin
          chk("rnd_wait_stall", {31'd0, memStall}, 32'd1);
        end
        next_cycle();
      end
      if (!done) chk("rnd_txn_bound", 32'd0, 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'h1234, 32'h40, 32'hBEEF, 32'h9, 4'd5, 1'b1, 32'h1234};
    vecs[1] = '{2'd2, 32'h1111, 32'h40, 32'hBEEF, 32'h9, 4'd6, 1'b1, 32'h40};
    vecs[2] = '{2'd3, 32'h1111, 32'h40, 32'hBEEF, 32'h9, 4'd7, 1'b1, 32'hBEEF};
    vecs[3] = '{2'd1, 32'h1111, 32'h40, 32'hBEEF, 32'hD00D, 4'd8, 1'b1, 32'hD00D};
    vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 4'd15, 1'b0, 32'hFFFF_FFFF};
    vecs[5] = '{2'd2, 32'h0, 32'h8000_0000, 32'h1, 32'h2, 4'd0, 1'b1, 32'h8000_0000};

    // Reset state.
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    chk("rst_rden", {31'd0, memRdEn}, 32'd0);
    chk("rst_wren", {31'd0, memWrEn}, 32'd0);
    chk("rst_addr", memAddr, 32'd0);
    chk("rst_wdata", memWrData, 32'd0);
    chk("rst_err", {31'd0, memErr}, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Direct (non-memory) writeback table.
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      inMulSel = vecs[i].sel; inAluOut = vecs[i].alu; inPC = vecs[i].pc;
      inSysDataOut = vecs[i].sys; memRdData = vecs[i].rd;
      inWrtIndex = vecs[i].idx; inRegWrEn = vecs[i].wen;
      #1;
      chk("tbl_wen", {31'd0, regWrEn}, {31'd0, vecs[i].wen});
      chk("tbl_idx", {28'd0, regWrIndex}, {28'd0, vecs[i].idx});
      chk("tbl_data", regWrData, vecs[i].exp_data);
      chk("tbl_stall", {31'd0, memStall}, 32'd0);
      next_cycle();
    end

    // Load completing in the first REQ cycle.
    clear_inputs();
    inIsLoad = 1'b1; inAluOut = 32'h100; inWrtIndex = 4'd3; inRegWrEn = 1'b1; inMulSel = 2'd1;
    #1;
    chk("ld_acc_stall", {31'd0, memStall}, 32'd1);
    chk("ld_acc_wen", {31'd0, regWrEn}, 32'd0);
    next_cycle();
    memReady = 1'b1; memRdData = 32'hCAFE;
    #1;
    chk("ld_rden", {31'd0, memRdEn}, 32'd1);
    chk("ld_addr", memAddr, 32'h100);
    chk("ld_wen", {31'd0, regWrEn}, 32'd1);
    chk("ld_idx", {28'd0, regWrIndex}, 32'd3);
    chk("ld_data", regWrData, 32'hCAFE);
    chk("ld_stall", {31'd0, memStall}, 32'd0);
    next_cycle();
    clear_inputs();
    #1;
    chk("ld_rden_off", {31'd0, memRdEn}, 32'd0);
    next_cycle();

    // Store with three wait cycles.
    clear_inputs();
    inIsStore = 1'b1; inData2Out = 32'h55; inAluOut = 32'h200; inRegWrEn = 1'b1; inWrtIndex = 4'd9;
    #1;
    chk("st_acc_stall", {31'd0, memStall}, 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wait_wren", {31'd0, memWrEn}, 32'd1);
      chk("st_wait_wdata", memWrData, 32'h55);
      chk("st_wait_stall", {31'd0, memStall}, 32'd1);
      next_cycle();
    end
    memReady = 1'b1;
    #1;
    chk("st_cmp_wren", {31'd0, memWrEn}, 32'd1);
    chk("st_cmp_wen", {31'd0, regWrEn}, 32'd0);
    chk("st_cmp_stall", {31'd0, memStall}, 32'd0);
    next_cycle();
    clear_inputs();
    #1;
    chk("st_wren_off", {31'd0, memWrEn}, 32'd0);
    next_cycle();

    // Timeout abort in the fourth REQ cycle.
    inIsLoad = 1'b1; inAluOut = 32'h300; inRegWrEn = 1'b1; inWrtIndex = 4'd2;
    next_cycle();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      #1;
      chk("to_wait_stall", {31'd0, memStall}, 32'd1);
      next_cycle();
    end
    #1;
    chk("to_abort_stall", {31'd0, memStall}, 32'd0);
    chk("to_abort_wen", {31'd0, regWrEn}, 32'd0);
    next_cycle();
    clear_inputs();
    inRegWrEn = 1'b1; inAluOut = 32'h77;
    #1;
    chk("to_err_set", {31'd0, memErr}, 32'd1);
    chk("to_rden_off", {31'd0, memRdEn}, 32'd0);
    next_cycle();
    #1;
    chk("to_err_sticky", {31'd0, memErr}, 32'd1);

    // Reset during the second REQ cycle.
    clear_inputs();
    inIsLoad = 1'b1; inAluOut = 32'h400; inRegWrEn = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rr_wen", {31'd0, regWrEn}, 32'd0);
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rr_rden", {31'd0, memRdEn}, 32'd0);
    chk("rr_err", {31'd0, memErr}, 32'd0);
    chk("rr_stall", {31'd0, memStall}, 32'd0);
    chk("rr_wen_after", {31'd0, regWrEn}, 32'd0);
    next_cycle();
    err_m = 1'b0;

    // Randomized instruction stream.
    for (int t = 0; t < 60; t++) run_random();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage directly downstream of the execute/memory pipeline register.
- Consumes the registered ALU result, store data, PC, system-register data, write index and control flags.
- Performs data-memory loads and stores over a valid/ready handshake and drives the register-file write port.
- Raises memStall to hold upstream stages while a memory access is outstanding, with a timeout that aborts hung accesses.

Parameters:
DBITS, 32, data/address width
REGNO_BITS, 4, register index width
MEM_TIMEOUT, 255, maximum cycles waiting in REQ before abort (1..255, 8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inWrtIndex  in  REGNO_BITS  destination register index
inRegWrEn  in  1  register write enable
inMulSel  in  2  writeback select: 0 ALU, 1 load data, 2 PC, 3 sys data
inAluOut  in  DBITS  ALU result / memory address
inData2Out  in  DBITS  store data
inPC  in  DBITS  return PC for link writeback
inSysDataOut  in  DBITS  system register read data
inIsLoad  in  1  load instruction
inIsStore  in  1  store instruction
memAddr  out  DBITS  data-memory address (registered)
memWrData  out  DBITS  store data (registered)
memRdEn  out  1  load request (registered)
memWrEn  out  1  store request (registered)
memReady  in  1  memory completion; load data valid this cycle
memRdData  in  DBITS  load data
regWrEn  out  1  register-file write enable
regWrIndex  out  REGNO_BITS  register-file write index
regWrData  out  DBITS  register-file write data
memStall  out  1  hold upstream stages
memErr  out  1  sticky timeout error

Behaviour:
- FSM has two states: IDLE and REQ. Reset: state IDLE, memRdEn=memWrEn=0, memAddr=memWrData=0, latched controls 0, timeout counter 0, memErr=0.
- IDLE, no memory op (inIsLoad=inIsStore=0):
  - Combinational writeback in the same cycle: regWrEn=inRegWrEn, regWrIndex=inWrtIndex.
  - regWrData selected by inMulSel: 0 inAluOut, 1 memRdData (undefined use; still muxed), 2 inPC, 3 inSysDataOut.
  - memStall=0.
- IDLE, memory op: memStall=1 combinationally and regWrEn=0. On the clock edge:
  - Latch inWrtIndex, inRegWrEn, inMulSel.
  - Set memAddr=inAluOut, memWrData=inData2Out, and memRdEn=inIsLoad or memWrEn=inIsStore.
  - Clear the counter and go to REQ.
- inIsLoad and inIsStore both high is treated as a store only.
- REQ, request held stable:
  - memReady=1: complete. For a load, regWrEn=latched RegWrEn, regWrIndex=latched index, regWrData=memRdData (mulSel 1) or the latched-select source. For a store, regWrEn=0. memStall=0 this cycle. Next state IDLE, enables cleared.
  - memReady=0: memStall=1, counter increments. When the counter equals MEM_TIMEOUT-1 and memReady=0: abort, memStall=0 that cycle, no register write, memErr set (sticky until reset), enables cleared, next state IDLE.
- memReady is ignored in IDLE.
- Minimum memory-op latency: accepted in cycle N, request visible in N+1, earliest completion N+1, next instruction accepted N+2.
- Upstream inputs stay stable while memStall=1. The same load is not re-accepted in REQ.
- Reset mid-REQ: request dropped immediately at the edge, no register write, memErr cleared.

Optional Feature:
MEM_WB_BYPASS_EN
- Defined: registered forwarding outputs fwdValid (1), fwdIndex (REGNO_BITS), fwdData (DBITS) capture regWrEn/regWrIndex/regWrData each cycle, giving upstream a one-cycle-late bypass of the last write. Reset value 0.
- Undefined: these ports and registers are absent. Upstream must rely on register-file write-before-read.

Test Plan:
- ALU op: inMulSel=0, inAluOut=0x1234, inWrtIndex=5, inRegWrEn=1 -> same cycle regWrEn=1, regWrIndex=5, regWrData=0x1234, memStall=0.
- Link op: inMulSel=2, inPC=0x40 -> regWrData=0x40. inMulSel=3, inSysDataOut=0xBEEF -> regWrData=0xBEEF.
- Load, memReady in first REQ cycle: inIsLoad=1, inAluOut=0x100, index 3 -> cycle N memStall=1. Cycle N+1 memRdEn=1, memAddr=0x100; memReady=1 with memRdData=0xCAFE -> regWrEn=1, index 3, data 0xCAFE, memStall=0. Cycle N+2 memRdEn=0.
- Store with 3-cycle wait: inIsStore=1, inData2Out=0x55 -> memWrEn=1 and memWrData=0x55 held for 3 cycles, memStall=1 throughout, regWrEn=0 on completion.
- Timeout: load with memReady held 0 and MEM_TIMEOUT=4 -> abort in 4th REQ cycle: memStall=0, no write, memErr=1 and stays 1 until reset.
- Reset asserted in 2nd REQ cycle -> next cycle memRdEn=0, memErr=0, state IDLE, no regWrEn pulse.
